// File: rtl/note_mux_pkg.sv
// note_mux_pkg -- shared definitions for the note slot multiplexer and the
// note slot demultiplexer.
//   NSLOTS_DEF : default number of time-division slots per frame
//   NOTE_W_DEF : default width of one note x-coordinate word
//   SLOT_W_DEF : default width of the multiplexer slot counter
//   FCNT_W     : width of the committed-frame counter
//   slot_state_t : frame assembly states (IDLE, FILL)
package note_mux_pkg;

   localparam int NSLOTS_DEF = 32;
   localparam int NOTE_W_DEF = 10;
   localparam int SLOT_W_DEF = 6;
   localparam int FCNT_W     = 16;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } slot_state_t;

endpackage

// File: rtl/note_slot_demux_if.sv
// note_slot_demux_if -- bus between the note source and the slot demux.
//   in_valid    : qualifies x_in / slot_in this cycle
//   x_in        : serial note word from the slot multiplexer
//   slot_in     : multiplexer counter, names the slot AFTER the one carried
//   notes_out   : committed frame, slot k at [k*NOTE_W +: NOTE_W]
//   frame_valid : one-cycle pulse when notes_out updates
//   frame_count : committed-frame count, wraps 65535 -> 0
//   sync_err    : one-cycle pulse on a sequence violation
// Modports: master drives the stream and observes results; slave is the demux.
interface note_slot_demux_if
   import note_mux_pkg::*;
#(
   parameter int NSLOTS = NSLOTS_DEF,
   parameter int NOTE_W = NOTE_W_DEF,
   parameter int SLOT_W = SLOT_W_DEF
);

   logic                     in_valid;
   logic [NOTE_W-1:0]        x_in;
   logic [SLOT_W-1:0]        slot_in;
   logic [NSLOTS*NOTE_W-1:0] notes_out;
   logic                     frame_valid;
   logic [FCNT_W-1:0]        frame_count;
   logic                     sync_err;

   modport master (
      output in_valid, x_in, slot_in,
      input  notes_out, frame_valid, frame_count, sync_err
   );

   modport slave (
      input  in_valid, x_in, slot_in,
      output notes_out, frame_valid, frame_count, sync_err
   );

endinterface

// File: rtl/note_slot_tracker.sv
// note_slot_tracker -- frame sequencing FSM for note_slot_demux.
// Decodes the slot a word belongs to, tracks the expected next slot and
// decides per valid word whether it is written to the shadow frame and
// whether it completes (commits) the frame.
//   clk_in, rst : clock, synchronous active-high reset
//   in_valid    : word qualifier
//   slot_in     : multiplexer counter (names the next slot)
//   idx         : decoded slot of the current word
//   wr_en       : write current word into shadow[idx]
//   commit      : current word completes the frame
//   sync_err    : registered one-cycle sequence-violation pulse
// Optional feature: define NOTE_SLOT_DEMUX_SEQ_CHECK_EN for strict sequence
// checking; otherwise gaps are tolerated and sync_err is tied low.
module note_slot_tracker
   import note_mux_pkg::*;
#(
   parameter int NSLOTS = NSLOTS_DEF,
   parameter int SLOT_W = SLOT_W_DEF
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [SLOT_W-1:0] slot_in,
   output logic [SLOT_W-1:0] idx,
   output logic              wr_en,
   output logic              commit,
   output logic              sync_err
);

   localparam logic [SLOT_W-1:0] LAST = SLOT_W'(NSLOTS - 1);
   localparam logic [SLOT_W-1:0] ONE  = SLOT_W'(1);

   slot_state_t       state_q, state_d;
   logic [SLOT_W-1:0] exp_q, exp_d;
   logic              in_range;

   // The counter has already advanced past the word it carries.
   assign in_range = int'(slot_in) < NSLOTS;
   assign idx      = (slot_in == '0) ? LAST : slot_in - ONE;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q <= IDLE;
         exp_q   <= '0;
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
      end
   end

`ifdef NOTE_SLOT_DEMUX_SEQ_CHECK_EN
   logic err_d, err_q;

   always_ff @(posedge clk_in) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign sync_err = err_q;
`else
   assign sync_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      wr_en   = 1'b0;
      commit  = 1'b0;
`ifdef NOTE_SLOT_DEMUX_SEQ_CHECK_EN
      err_d   = 1'b0;
`endif
      if (in_valid) begin
         case (state_q)
            IDLE: begin
               if (in_range && idx == '0) begin
                  wr_en   = 1'b1;
                  exp_d   = ONE;
                  state_d = FILL;
               end
            end
            FILL: begin
`ifdef NOTE_SLOT_DEMUX_SEQ_CHECK_EN
               if (in_range && idx == exp_q) begin
                  wr_en  = 1'b1;
                  commit = (idx == LAST);
                  exp_d  = (idx == LAST) ? '0 : idx + ONE;
               end else begin
                  // Partial frame is dropped; a slot-0 word restarts at once.
                  err_d = 1'b1;
                  if (in_range && idx == '0) begin
                     wr_en = 1'b1;
                     exp_d = ONE;
                  end else begin
                     exp_d   = '0;
                     state_d = IDLE;
                  end
               end
`else
               if (in_range) begin
                  wr_en  = 1'b1;
                  commit = (idx == LAST);
                  exp_d  = (idx == LAST) ? '0 : idx + ONE;
               end
`endif
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: rtl/note_slot_demux.sv
// note_slot_demux -- rebuilds a parallel note frame from the time-division
// slot stream. Words are collected in a shadow frame; when the last slot
// arrives the whole frame (with that last word) is committed to notes_out on
// the next edge.
//   clk_in : clock, all logic on posedge
//   rst    : synchronous active-high reset, clears frame, counters and FSM
//   bus    : note_slot_demux_if.slave (stream in, frame/status out)
// Optional feature: define NOTE_SLOT_DEMUX_SEQ_CHECK_EN for strict slot
// sequence checking with sync_err reporting.
module note_slot_demux
   import note_mux_pkg::*;
#(
   parameter int NSLOTS = NSLOTS_DEF,
   parameter int NOTE_W = NOTE_W_DEF,
   parameter int SLOT_W = SLOT_W_DEF
) (
   input logic              clk_in,
   input logic              rst,
   note_slot_demux_if.slave bus
);

   logic [SLOT_W-1:0]        idx;
   logic                     wr_en;
   logic                     commit;

   logic [NSLOTS*NOTE_W-1:0] shadow_p0;
   logic [NSLOTS*NOTE_W-1:0] notes_p1;
   logic                     vld_p1;
   logic [FCNT_W-1:0]        cnt_p1;

   note_slot_tracker #(
      .NSLOTS (NSLOTS),
      .SLOT_W (SLOT_W)
   ) u_tracker (
      .clk_in   (clk_in),
      .rst      (rst),
      .in_valid (bus.in_valid),
      .slot_in  (bus.slot_in),
      .idx      (idx),
      .wr_en    (wr_en),
      .commit   (commit),
      .sync_err (bus.sync_err)
   );

   // Stage p0 -> p1: shadow write and frame commit
   always_ff @(posedge clk_in) begin
      if (rst) begin
         shadow_p0 <= '0;
         notes_p1  <= '0;
         vld_p1    <= 1'b0;
         cnt_p1    <= '0;
      end else begin
         vld_p1 <= commit;
         for (int k = 0; k < NSLOTS; k++) begin
            if (wr_en && idx == SLOT_W'(k)) shadow_p0[k*NOTE_W +: NOTE_W] <= bus.x_in;
         end
         if (commit) begin
            // The last word is not in the shadow yet, so take it straight in.
            notes_p1 <= {bus.x_in, shadow_p0[(NSLOTS-1)*NOTE_W-1:0]};
            cnt_p1   <= cnt_p1 + FCNT_W'(1);
         end
      end
   end

   assign bus.notes_out   = notes_p1;
   assign bus.frame_valid = vld_p1;
   assign bus.frame_count = cnt_p1;

endmodule

// File: tb/tb_note_slot_demux.sv
module tb_note_slot_demux;
   import note_mux_pkg::*;

   localparam int NSLOTS = NSLOTS_DEF;
   localparam int NOTE_W = NOTE_W_DEF;
   localparam int SLOT_W = SLOT_W_DEF;
   localparam int W      = NSLOTS * NOTE_W;

   typedef struct {
      int          cyc;
      logic [W-1:0] notes;
      logic [15:0]  cnt;
   } frm_t;

   logic clk_in = 1'b0;
   logic rst;
   logic rst_seen;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   frm_t fq[$];
   int   eq[$];
   logic [W-1:0] cur_notes = '0;

   // reference state
   logic [NOTE_W-1:0] m_sh[NSLOTS];
   bit   m_fill;
   int   m_exp;
   int   m_cnt;

   always #5 clk_in = ~clk_in;

   note_slot_demux_if #(.NSLOTS(NSLOTS), .NOTE_W(NOTE_W), .SLOT_W(SLOT_W)) bus ();

   note_slot_demux #(.NSLOTS(NSLOTS), .NOTE_W(NOTE_W), .SLOT_W(SLOT_W)) dut (
      .clk_in (clk_in),
      .rst    (rst),
      .bus    (bus)
   );

   always @(posedge clk_in) begin
      cyc      <= cyc + 1;
      rst_seen <= rst;
   end

   task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NSLOTS; k++) m_sh[k] = '0;
      m_fill = 1'b0;
      m_exp  = 0;
      m_cnt  = 0;
   endtask

   task automatic model_accept(int idx, int x);
      frm_t f;
      m_sh[idx] = NOTE_W'(x);
      m_exp     = (idx + 1) % NSLOTS;
      if (idx == NSLOTS - 1) begin
         m_cnt = (m_cnt + 1) % 65536;
         for (int k = 0; k < NSLOTS; k++) f.notes[k*NOTE_W +: NOTE_W] = m_sh[k];
         f.cnt = 16'(m_cnt);
         f.cyc = cyc + 1;
         fq.push_back(f);
      end
   endtask

   task automatic model(int s, int x);
      bit inr;
      int idx;
      inr = (s < NSLOTS);
      idx = (s + NSLOTS - 1) % NSLOTS;
      if (!m_fill) begin
         if (inr && idx == 0) begin
            m_sh[0] = NOTE_W'(x);
            m_exp   = 1;
            m_fill  = 1'b1;
         end
      end else begin
`ifdef NOTE_SLOT_DEMUX_SEQ_CHECK_EN
         if (inr && idx == m_exp) model_accept(idx, x);
         else begin
            eq.push_back(cyc + 1);
            if (inr && idx == 0) begin
               m_sh[0] = NOTE_W'(x);
               m_exp   = 1;
            end else begin
               m_fill = 1'b0;
               m_exp  = 0;
            end
         end
`else
         if (inr) model_accept(idx, x);
`endif
      end
   endtask

   task automatic send(int s, int x);
      bus.in_valid = 1'b1;
      bus.slot_in  = SLOT_W'(s);
      bus.x_in     = NOTE_W'(x);
      model(s, x);
      @(negedge clk_in);
      bus.in_valid = 1'b0;
   endtask

   task automatic send_range(int lo, int hi, int base);
      for (int i = lo; i <= hi; i++) send((i + 1) % NSLOTS, base + i);
   endtask

   task automatic send_frame(int base, int step);
      for (int i = 0; i < NSLOTS; i++) send((i + 1) % NSLOTS, base + i * step);
   endtask

   task automatic idle(int n);
      repeat (n) @(negedge clk_in);
   endtask

   // Reset with a valid word present to show reset wins over in_valid.
   task automatic do_reset();
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.slot_in  = SLOT_W'(18);
      bus.x_in     = NOTE_W'(77);
      model_reset();
      @(negedge clk_in);
      bus.in_valid = 1'b0;
      @(negedge clk_in);
      chk("rst_notes", bus.notes_out, W'(0));
      chk("rst_fv", W'(bus.frame_valid), W'(0));
      chk("rst_count", W'(bus.frame_count), W'(0));
      chk("rst_err", W'(bus.sync_err), W'(0));
      rst = 1'b0;
   endtask

   // output monitor / scoreboard
   initial begin
      frm_t e;
      int   ec;
      forever begin
         @(negedge clk_in);
         if (rst_seen === 1'b1) cur_notes = '0;
         else begin
            if (bus.frame_valid) begin
               if (fq.size() == 0) chk("spurious_fv", W'(1), W'(0));
               else begin
                  e = fq.pop_front();
                  chk("fv_cycle", W'(cyc), W'(e.cyc));
                  chk("frame_notes", bus.notes_out, e.notes);
                  chk("frame_count", W'(bus.frame_count), W'(e.cnt));
                  cur_notes = e.notes;
               end
            end
            if (bus.sync_err) begin
               if (eq.size() == 0) chk("spurious_err", W'(1), W'(0));
               else begin
                  ec = eq.pop_front();
                  chk("err_cycle", W'(cyc), W'(ec));
               end
            end
         end
         chk("notes_hold", bus.notes_out, cur_notes);
      end
   end

   initial begin
      logic [NOTE_W-1:0] slot5;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.slot_in  = '0;
      bus.x_in     = '0;
      model_reset();
      @(negedge clk_in);
      do_reset();

      // basic frame, slot k = 100 + k
      send_frame(100, 1);
      chk("first_count", W'(bus.frame_count), W'(1));
      chk("first_fv", W'(bus.frame_valid), W'(1));
      slot5 = bus.notes_out[5*NOTE_W +: NOTE_W];
      chk("first_slot5", W'(slot5), W'(105));
      send_frame(7, 3);
      idle(2);

      // stream joins mid-frame
      do_reset();
      for (int s = 10; s < NSLOTS; s++) send(s, 500 + s);
      send(0, 600);
      send_frame(200, 2);

      // 5-cycle gap after idx 15
      send_range(0, 15, 300);
      idle(5);
      send_range(16, 31, 300);

      // idx 20 skipped, then a clean frame
      send_range(0, 19, 400);
      send_range(21, 31, 400);
      send_frame(50, 5);

      // out-of-range slot counter values mid-frame
      send_range(0, 9, 600);
      send(40, 1);
      send(63, 2);
      send_range(10, 31, 600);
      send_frame(20, 1);

      // reset in the middle of a frame
      send_range(0, 16, 700);
      do_reset();
      send_frame(800, 1);
      chk("count_after_rst", W'(bus.frame_count), W'(1));

      // frame counter wrap
      force dut.cnt_p1 = 16'hFFFF;
      @(negedge clk_in);
      release dut.cnt_p1;
      m_cnt = 65535;
      send_frame(900, 1);
      chk("wrap_count", W'(bus.frame_count), W'(0));
      chk("wrap_fv", W'(bus.frame_valid), W'(1));

      idle(4);
      chk("frames_left", W'(fq.size()), W'(0));
      chk("errs_left", W'(eq.size()), W'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
